// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet convolution layer blocks.
// Holds feature-map geometry, pixel width, kernel size and the tap-reader state type.
package lenet_pkg;

   localparam int DATA_W = 16;
   localparam int IMG_W  = 32;
   localparam int IMG_H  = 32;
   localparam int K      = 5;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } tap_state_t;

endpackage

// File: rtl/line_fifo.sv
// Single-row shift buffer: DEPTH words of DATA_W, shifting on shift_en.
// Ports: clk, shift_en, din (newest word), dout (oldest word, DEPTH shifts old).
module line_fifo #(
   parameter int DATA_W = lenet_pkg::DATA_W,
   parameter int DEPTH  = lenet_pkg::IMG_W
) (
   input  logic              clk,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   // No reset: contents are always refilled before they are exposed.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (shift_en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/line_tap_reader.sv
// Buffers K-1 rows of a raster pixel stream and emits a K-tap vertical column per pixel.
// Ports: clk, reset, din_valid, din -> col_out, col_valid, col_x, row_last, frame_done.
module line_tap_reader #(
   parameter int DATA_W = lenet_pkg::DATA_W,
   parameter int IMG_W  = lenet_pkg::IMG_W,
   parameter int IMG_H  = lenet_pkg::IMG_H,
   parameter int K      = lenet_pkg::K
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       din_valid,
   input  logic signed [DATA_W-1:0]   din,
   output logic [K*DATA_W-1:0]        col_out,
   output logic                       col_valid,
   output logic [$clog2(IMG_W)-1:0]   col_x,
   output logic                       row_last,
   output logic                       frame_done
);

   import lenet_pkg::*;

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int NB = K - 1;

   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [YW-1:0] Y_FILL = YW'(K - 2);

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   tap_state_t    state;

   logic [DATA_W-1:0] chain_d [NB];
   logic [DATA_W-1:0] line_q  [NB];
   logic [K*DATA_W-1:0] taps;

   logic x_end;
   logic f_end;
   logic strm;

   // Buffer g outputs row y-1-g; each feeds the next buffer in the cascade.
   for (genvar g = 0; g < NB; g++) begin : g_line
      if (g == 0) begin : g_head
         assign chain_d[g] = din;
      end else begin : g_body
         assign chain_d[g] = line_q[g-1];
      end
      line_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (IMG_W)
      ) u_fifo (
         .clk      (clk),
         .shift_en (din_valid),
         .din      (chain_d[g]),
         .dout     (line_q[g])
      );
   end

   // Tap 0 is the oldest row, i.e. the deepest buffer.
   always_comb begin
      taps = '0;
      taps[NB*DATA_W +: DATA_W] = din;
      for (int k = 0; k < NB; k++) begin
         taps[k*DATA_W +: DATA_W] = line_q[NB-1-k];
      end
   end

   assign x_end = (x == X_LAST);
   assign f_end = x_end && (y == Y_LAST);
   assign strm  = (state == STREAM);

   always_ff @(posedge clk) begin
      if (reset) begin
         x          <= '0;
         y          <= '0;
         state      <= FILL;
         col_out    <= '0;
         col_valid  <= 1'b0;
         col_x      <= '0;
         row_last   <= 1'b0;
         frame_done <= 1'b0;
      end else if (din_valid) begin
         col_out    <= taps;
         col_x      <= x;
         col_valid  <= strm;
         row_last   <= strm && x_end;
         frame_done <= strm && f_end;
         if (x_end) begin
            x <= '0;
            y <= f_end ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
         unique case (state)
            FILL: begin
               if (x_end && (y == Y_FILL)) begin
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (f_end) begin
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end else begin
         col_valid  <= 1'b0;
         row_last   <= 1'b0;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_line_tap_reader.sv
// Directed bench for line_tap_reader: fill, stream, gaps, signed data,
// back-to-back frames and mid-frame reset, checked against a pixel model.
module tb_line_tap_reader;

   logic        clk;
   logic        reset;
   logic        din_valid;
   logic [15:0] din;
   logic [79:0] col_out;
   logic        col_valid;
   logic [4:0]  col_x;
   logic        row_last;
   logic        frame_done;

   int n_pass;
   int n_fail;
   int n_total;

   int          nvalid;
   int          bad;
   int          gapv;
   int          fd;
   int          rl;
   int          first_idx;
   int          fd_sum;
   logic [79:0] col_34;
   logic [4:0]  cx_34;
   logic [79:0] col_04;

   line_tap_reader dut (
      .clk        (clk),
      .reset      (reset),
      .din_valid  (din_valid),
      .din        (din),
      .col_out    (col_out),
      .col_valid  (col_valid),
      .col_x      (col_x),
      .row_last   (row_last),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] pix(int px, int py, bit sgn);
      if (sgn && px == 0 && py == 0) return 16'h8000;
      if (sgn && px == 0 && py == 4) return 16'h7FFF;
      return 16'(py * 32 + px);
   endfunction

   task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one full frame and scores every output cycle against the model.
   task automatic send_frame(int gap_max, bit sgn);
      logic [79:0] ec;
      int idx;
      nvalid = 0; bad = 0; gapv = 0; fd = 0; rl = 0;
      first_idx = -1; idx = 0;
      for (int py = 0; py < 32; py++) begin
         for (int px = 0; px < 32; px++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int i = 0; i < g; i++) begin
               din_valid = 1'b0;
               din = 16'($urandom);
               tick();
               if (col_valid !== 1'b0) gapv++;
            end
            din_valid = 1'b1;
            din = pix(px, py, sgn);
            tick();
            if (col_valid) begin
               nvalid++;
               if (first_idx < 0) first_idx = idx;
            end
            if (frame_done) fd++;
            if (row_last) rl++;
            if (py >= 4) begin
               for (int k = 0; k < 5; k++) begin
                  ec[k*16 +: 16] = pix(px, py - 4 + k, sgn);
               end
               if (col_valid !== 1'b1) bad++;
               if (col_out !== ec) bad++;
               if (col_x !== 5'(px)) bad++;
               if (row_last !== (px == 31)) bad++;
               if (frame_done !== (px == 31 && py == 31)) bad++;
            end else begin
               if (col_valid !== 1'b0) bad++;
               if (frame_done !== 1'b0) bad++;
            end
            if (px == 3 && py == 4) begin
               col_34 = col_out;
               cx_34 = col_x;
            end
            if (px == 0 && py == 4) col_04 = col_out;
            idx++;
         end
      end
   endtask

   task automatic chk_reset_outs(string tag);
      chk({tag, "_col_out"}, col_out, 80'd0);
      chk({tag, "_col_valid"}, col_valid, 1'b0);
      chk({tag, "_col_x"}, col_x, 5'd0);
      chk({tag, "_row_last"}, row_last, 1'b0);
      chk({tag, "_frame_done"}, frame_done, 1'b0);
   endtask

   initial begin
      logic [79:0] e34;
      n_pass = 0; n_fail = 0; n_total = 0; fd_sum = 0;
      reset = 1'b1; din_valid = 1'b0; din = '0;
      tick(); tick();
      chk_reset_outs("rst");
      reset = 1'b0;
      tick();

      // Continuous frame.
      send_frame(0, 1'b0);
      din_valid = 1'b0;
      e34 = {16'd131, 16'd99, 16'd67, 16'd35, 16'd3};
      chk("cont_col34", col_34, e34);
      chk("cont_colx34", cx_34, 5'd3);
      chk("cont_tap0_04", col_04[15:0], 16'd0);
      chk("cont_tap4_04", col_04[79:64], 16'd128);
      chk("cont_nvalid", nvalid, 896);
      chk("cont_first", first_idx, 128);
      chk("cont_model", bad, 0);
      chk("cont_fd", fd, 1);
      chk("cont_rowlast", rl, 28);
      tick(); tick();
      chk("idle_valid", col_valid, 1'b0);

      // Random gaps.
      send_frame(3, 1'b0);
      din_valid = 1'b0;
      chk("gap_model", bad, 0);
      chk("gap_nvalid", nvalid, 896);
      chk("gap_after_idle", gapv, 0);
      chk("gap_col34", col_34, e34);
      tick();

      // Signed extremes.
      send_frame(0, 1'b1);
      din_valid = 1'b0;
      chk("sgn_tap0", col_04[15:0], 16'h8000);
      chk("sgn_tap4", col_04[79:64], 16'h7FFF);
      chk("sgn_model", bad, 0);
      tick();

      // Two back-to-back frames.
      send_frame(0, 1'b0);
      fd_sum = fd;
      chk("b2b_f1_model", bad, 0);
      send_frame(0, 1'b0);
      din_valid = 1'b0;
      fd_sum += fd;
      chk("b2b_fd", fd_sum, 2);
      chk("b2b_f2_first", first_idx, 128);
      chk("b2b_f2_model", bad, 0);
      chk("b2b_f2_nvalid", nvalid, 896);
      tick();

      // Reset at pixel (10, 7), then a fresh frame.
      for (int i = 0; i < 7 * 32 + 10; i++) begin
         din_valid = 1'b1;
         din = pix(i % 32, i / 32, 1'b0);
         tick();
      end
      chk("pre_rst_valid", col_valid, 1'b1);
      reset = 1'b1;
      din_valid = 1'b1;
      din = pix(10, 7, 1'b0);
      tick();
      chk_reset_outs("midrst");
      reset = 1'b0;
      din_valid = 1'b0;
      tick();
      send_frame(0, 1'b0);
      din_valid = 1'b0;
      chk("fresh_model", bad, 0);
      chk("fresh_nvalid", nvalid, 896);
      chk("fresh_first", first_idx, 128);
      chk("fresh_col34", col_34, e34);
      chk("fresh_fd", fd, 1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
